// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_W / DATA_W  : address and instruction widths
//   INSTR_BYTES      : sequential PC increment
//   RESET_PC         : program_counter reset address
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : buffered {pc, instr} pair handed to decode
package fetch_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO holding fetched {pc, instr} pairs for decode.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the buffer; wins over push and pop
//   count      : number of valid entries
//   head       : oldest entry, all-zero when empty
module fetch_buffer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign head   = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage between program_counter and decode. Issues one instruction
// memory read per PC value (at most one outstanding), buffers {pc, instr}
// pairs, and steers the PC: PC+INSTR_BYTES after each fetch, or a redirect.
//   clk, reset              : clock, synchronous active-high reset
//   pc_addr, pc_updated     : current_address / address_updated from the PC
//   pc_write_enable         : 1-cycle pulse to the PC
//   pc_new_address          : value written into the PC
//   imem_req_valid/ready    : read request handshake
//   imem_addr               : read address, stable while imem_req_valid
//   imem_rsp_valid/data     : read response
//   redirect_valid/addr     : branch/jump redirect pulse and target
//   if_valid/ready          : decode handshake on the buffer head
//   if_pc, if_instr         : head entry
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_updated,
    output logic              pc_write_enable,
    output logic [ADDR_W-1:0] pc_new_address,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] req_addr;
    logic              discard;
    logic              block;
    logic              update_seen;
    logic              start;
    logic              push;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign imem_addr  = req_addr;
    assign push_entry = '{pc: req_addr, instr: imem_rsp_data};
    assign if_valid   = (count != '0);
    assign if_pc      = head_entry.pc;
    assign if_instr   = head_entry.instr;

    fetch_buffer #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (if_valid && if_ready),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        start          = 1'b0;
        push           = 1'b0;
        unique case (state)
            IDLE: begin
                if ((pc_updated || update_seen) && !block && !redirect_valid &&
                    (count < DEPTH_C)) begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push       = !discard && !redirect_valid;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // update_seen remembers an address_updated pulse that arrived while the
    // buffer was full, so the fetch starts once decode frees an entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr        <= '0;
            discard         <= 1'b0;
            block           <= 1'b0;
            update_seen     <= 1'b0;
            pc_write_enable <= 1'b0;
            pc_new_address  <= '0;
        end else begin
            block           <= redirect_valid;
            pc_write_enable <= redirect_valid || push;
            if (redirect_valid) begin
                pc_new_address <= redirect_addr;
            end else if (push) begin
                pc_new_address <= req_addr + ADDR_W'(INSTR_BYTES);
            end

            if (start) begin
                req_addr <= pc_addr;
            end

            if (redirect_valid && (state == REQ || (state == WAIT && !imem_rsp_valid))) begin
                discard <= 1'b1;
            end else if (state == WAIT && imem_rsp_valid) begin
                discard <= 1'b0;
            end

            if (redirect_valid || start) begin
                update_seen <= 1'b0;
            end else if (pc_updated && !block) begin
                update_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_updated;
    logic              pc_write_enable;
    logic [ADDR_W-1:0] pc_new_address;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned latency;
    int unsigned mem_cnt;
    logic              mem_busy;
    logic [ADDR_W-1:0] mem_raddr;

    fetch_entry_t      pop_log[$];
    logic [ADDR_W-1:0] we_log[$];
    logic [ADDR_W-1:0] req_log[$];

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_addr         (pc_addr),
        .pc_updated      (pc_updated),
        .pc_write_enable (pc_write_enable),
        .pc_new_address  (pc_new_address),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // program_counter: address_updated follows a write by one cycle, and
    // pulses once after reset.
    always @(posedge clk) begin
        if (reset) begin
            pc_addr    <= RESET_PC;
            pc_updated <= 1'b1;
        end else begin
            pc_updated <= pc_write_enable;
            if (pc_write_enable) pc_addr <= pc_new_address;
        end
    end

    // instruction memory: response 'latency' cycles after acceptance
    always @(posedge clk) begin
        if (reset) begin
            mem_busy       <= 1'b0;
            mem_cnt        <= 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            mem_raddr      <= '0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                if (latency <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(imem_addr);
                end else begin
                    mem_busy  <= 1'b1;
                    mem_cnt   <= latency - 1;
                    mem_raddr <= imem_addr;
                end
            end else if (mem_busy) begin
                if (mem_cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(mem_raddr);
                    mem_busy       <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (pc_write_enable) we_log.push_back(pc_new_address);
            if (if_valid && if_ready) pop_log.push_back('{pc: if_pc, instr: if_instr});
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_req(input string tag);
        int unsigned n = 0;
        while (!imem_req_valid && n < 100) begin @(negedge clk); n++; end
        if (!imem_req_valid) check({tag, "_timeout"}, imem_req_valid, 1);
    endtask

    task automatic wait_if_valid(input string tag);
        int unsigned n = 0;
        while (!if_valid && n < 100) begin @(negedge clk); n++; end
        if (!if_valid) check({tag, "_timeout"}, if_valid, 1);
    endtask

    task automatic wait_pops(input int unsigned want, input string tag);
        int unsigned n = 0;
        while (pop_log.size() < want && n < 200) begin @(negedge clk); n++; end
        if (pop_log.size() < want) check({tag, "_timeout"}, pop_log.size(), want);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        pop_log.delete();
        we_log.delete();
        req_log.delete();
    endtask

    initial begin
        int unsigned bad;
        reset          = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_req_ready = 1'b1;
        latency        = 1;
        repeat (3) @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_pc_we", pc_write_enable, 0);

        // first fetch after reset
        reset = 1'b0;
        wait_req("t1_req");
        check("t1_imem_addr", imem_addr, 32'h0100_0000);
        wait_if_valid("t1_if");
        check("t1_if_pc", if_pc, 32'h0100_0000);
        check("t1_if_instr", if_instr, mem_word(32'h0100_0000));
        check("t1_pc_we", pc_write_enable, 1);
        check("t1_pc_new", pc_new_address, 32'h0100_0004);

        // streaming with decode always ready
        pop_log.delete();
        we_log.delete();
        if_ready = 1'b1;
        wait_pops(3, "t2");
        if_ready = 1'b0;
        check("t2_pop_count", pop_log.size(), 3);
        check("t2_we_count", we_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_pc%0d", i), pop_log[i].pc, 32'h0100_0000 + 32'(4 * i));
            check($sformatf("t2_instr%0d", i), pop_log[i].instr,
                  mem_word(32'h0100_0000 + 32'(4 * i)));
            check($sformatf("t2_we_addr%0d", i), we_log[i], 32'h0100_0004 + 32'(4 * i));
        end

        // backpressure: full buffer stops requests, one pop frees one
        repeat (40) @(negedge clk);
        req_log.delete();
        repeat (20) @(negedge clk);
        check("t3_no_req", req_log.size(), 0);
        check("t3_req_valid", imem_req_valid, 0);
        check("t3_head", if_pc, 32'h0100_000C);
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        check("t3_head_after_pop", if_pc, 32'h0100_0010);
        repeat (30) @(negedge clk);
        check("t3_one_req", req_log.size(), 1);
        check("t3_req_addr", req_log[0], 32'h0100_0014);

        // redirect while waiting on a slow response
        do_reset();
        latency  = 3;
        if_ready = 1'b1;
        reset    = 1'b0;
        wait_req("t4_req");
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0100_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t4_pc_new", pc_new_address, 32'h0100_0100);
        repeat (40) @(negedge clk);
        if_ready = 1'b0;
        check("t4_first_pc", pop_log[0].pc, 32'h0100_0100);
        check("t4_first_instr", pop_log[0].instr, mem_word(32'h0100_0100));
        check("t4_second_req", req_log[1], 32'h0100_0100);
        bad = 0;
        foreach (pop_log[i])
            if (pop_log[i].pc == 32'h0100_0000 || pop_log[i].pc == 32'h0100_0004) bad++;
        check("t4_no_stale", bad, 0);

        // redirect coinciding with a pop and an arriving response
        do_reset();
        latency  = 1;
        if_ready = 1'b0;
        reset    = 1'b0;
        wait_if_valid("t5_first");
        wait_req("t5_req");
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0200_0000;
        if_ready       = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        check("t5_flushed", if_valid, 0);
        check("t5_pc_we", pc_write_enable, 1);
        check("t5_pc_new", pc_new_address, 32'h0200_0000);
        @(negedge clk);
        check("t5_single_we", pc_write_enable, 0);
        wait_if_valid("t5_refetch");
        check("t5_if_pc", if_pc, 32'h0200_0000);

        // back-to-back redirects: the later target wins
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0300_0000;
        @(negedge clk);
        redirect_addr  = 32'h0400_0000;
        check("b2b_first_new", pc_new_address, 32'h0300_0000);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("b2b_we", pc_write_enable, 1);
        check("b2b_last_new", pc_new_address, 32'h0400_0000);
        pop_log.delete();
        if_ready = 1'b1;
        wait_pops(1, "b2b");
        if_ready = 1'b0;
        check("b2b_pc", pop_log[0].pc, 32'h0400_0000);

        // address wrap, then reset in the middle of a request
        do_reset();
        latency        = 1;
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_if_valid("t6_if");
        check("t6_if_pc", if_pc, 32'hFFFF_FFFC);
        check("t6_pc_we", pc_write_enable, 1);
        check("t6_pc_wrap", pc_new_address, 32'h0000_0000);
        wait_req("t6_wrap_req");
        check("t6_wrap_addr", imem_addr, 32'h0000_0000);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_pc_we", pc_write_enable, 0);
        check("t6_rst_pc_new", pc_new_address, 0);
        check("t6_rst_req_valid", imem_req_valid, 0);
        check("t6_rst_imem_addr", imem_addr, 0);
        check("t6_rst_if_valid", if_valid, 0);
        check("t6_rst_if_pc", if_pc, 0);
        check("t6_rst_if_instr", if_instr, 0);
        imem_req_ready = 1'b0;
        reset          = 1'b0;
        wait_req("t6_restart");
        repeat (3) @(negedge clk);
        check("t6_hold_valid", imem_req_valid, 1);
        check("t6_hold_addr", imem_addr, 32'h0100_0000);
        imem_req_ready = 1'b1;
        wait_if_valid("t6_restart_if");
        check("t6_restart_pc", if_pc, 32'h0100_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
